// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg
// Shared definitions for the multi-channel LED controller:
//   - mode_e         : per-channel mode encoding (OFF / ON / BLINK / PWM)
//   - STAT_*         : bit positions of the fields in the status word
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    localparam int STAT_LED_LSB    = 0;
    localparam int STAT_LED_W      = 16;
    localparam int STAT_CLK_OUT    = 16;
    localparam int STAT_PHASE      = 17;
    localparam int STAT_TOGGLE_LSB = 24;
    localparam int STAT_TOGGLE_W   = 8;

endpackage

// File: rtl/led_ctrl_chan.sv
// led_ctrl_chan
// Combinational next-value logic for one LED channel; the result is
// registered in the top.
// Build option: LED_CTRL_PWM_EN -- when defined, mode 11 compares pwm_cnt
// against duty; when undefined, mode 11 acts as ON and duty/pwm_cnt are
// ignored.
// Ports:
//   mode        in   2      channel mode (led_ctrl_pkg::mode_e encoding)
//   duty        in   PWM_W  PWM duty
//   blink_phase in   1      shared blink phase
//   pwm_cnt     in   PWM_W  shared PWM counter
//   led_next    out  1      next LED value
module led_ctrl_chan
    import led_ctrl_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic [1:0]       mode,
    input  logic [PWM_W-1:0] duty,
    input  logic             blink_phase,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led_next
);

`ifndef LED_CTRL_PWM_EN
    logic pwm_inputs_unused;
    assign pwm_inputs_unused = ^{duty, pwm_cnt};
`endif

    always_comb begin
        led_next = 1'b0;
        case (mode)
            MODE_OFF:   led_next = 1'b0;
            MODE_ON:    led_next = 1'b1;
            MODE_BLINK: led_next = blink_phase;
`ifdef LED_CTRL_PWM_EN
            MODE_PWM:   led_next = (pwm_cnt < duty);
`else
            MODE_PWM:   led_next = 1'b1;
`endif
            default:    led_next = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_ctrl_multi.sv
// led_ctrl_multi
// Multi-channel LED controller: per-channel OFF/ON/BLINK/PWM, a shared
// blink timebase, a programmable clock divider and a live status word.
// Build option: LED_CTRL_PWM_EN -- when defined the PWM counter and
// comparators exist; when undefined mode 11 behaves as ON.
// Ports:
//   CLK         in   1              system clock
//   RST         in   1              synchronous active-high reset
//   mode_reg    in   2*NUM_LED      channel i mode in [2i+1:2i]
//   period_reg  in   CNT_W          blink half-period minus one
//   duty_reg    in   PWM_W*NUM_LED  channel i duty in [PWM_W*i +: PWM_W]
//   clkdiv_reg  in   CNT_W          clk_out half-period minus one
//   status_reg  out  32             {toggle_cnt, 6'b0, blink_phase, clk_out, led}
//   led         out  NUM_LED        LED drive, active-high
//   clk_out     out  1              divided clock
module led_ctrl_multi
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LED = 4,
    parameter int CNT_W   = 32,
    parameter int PWM_W   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [2*NUM_LED-1:0]     mode_reg,
    input  logic [CNT_W-1:0]         period_reg,
    input  logic [PWM_W*NUM_LED-1:0] duty_reg,
    input  logic [CNT_W-1:0]         clkdiv_reg,
    output logic [31:0]              status_reg,
    output logic [NUM_LED-1:0]       led,
    output logic                     clk_out
);

    logic [CNT_W-1:0]         blink_cnt;
    logic [CNT_W-1:0]         div_cnt;
    logic                     blink_phase;
    logic                     blink_phase_nxt;
    logic                     blink_tc;
    logic                     div_tc;
    logic [STAT_TOGGLE_W-1:0] toggle_cnt;
    logic [NUM_LED-1:0]       led_nxt;
    logic [PWM_W-1:0]         pwm_cnt_nxt;

    // >= rather than == so that lowering a limit below the running count
    // terminates on the next cycle instead of wrapping the counter.
    assign blink_tc        = (blink_cnt >= period_reg);
    assign div_tc          = (div_cnt >= clkdiv_reg);
    assign blink_phase_nxt = blink_phase ^ blink_tc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            toggle_cnt  <= '0;
            div_cnt     <= '0;
            clk_out     <= 1'b0;
            led         <= '0;
        end else begin
            blink_cnt   <= blink_tc ? '0 : blink_cnt + CNT_W'(1);
            blink_phase <= blink_phase_nxt;
            if (blink_tc) begin
                toggle_cnt <= toggle_cnt + STAT_TOGGLE_W'(1);
            end
            div_cnt     <= div_tc ? '0 : div_cnt + CNT_W'(1);
            if (div_tc) begin
                clk_out <= ~clk_out;
            end
            led         <= led_nxt;
        end
    end

`ifdef LED_CTRL_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    assign pwm_cnt_nxt = pwm_cnt + PWM_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt_nxt;
        end
    end
`else
    assign pwm_cnt_nxt = '0;
`endif

    // Channels see the next-state timebase so the registered led lines up
    // with the registered blink_phase in the same cycle.
    for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
        led_ctrl_chan #(
            .PWM_W(PWM_W)
        ) u_chan (
            .mode        (mode_reg[2*i +: 2]),
            .duty        (duty_reg[PWM_W*i +: PWM_W]),
            .blink_phase (blink_phase_nxt),
            .pwm_cnt     (pwm_cnt_nxt),
            .led_next    (led_nxt[i])
        );
    end

    // Built purely from registers, so it changes on the same edge as the
    // state it reports.
    always_comb begin
        status_reg = '0;
        status_reg[STAT_LED_LSB +: NUM_LED]             = led;
        status_reg[STAT_CLK_OUT]                        = clk_out;
        status_reg[STAT_PHASE]                          = blink_phase;
        status_reg[STAT_TOGGLE_LSB +: STAT_TOGGLE_W]    = toggle_cnt;
    end

endmodule

// File: tb/tb_led_ctrl_multi.sv
module tb_led_ctrl_multi;

    localparam int NUM_LED = 4;
    localparam int CNT_W   = 32;
    localparam int PWM_W   = 8;

    logic                     CLK = 1'b0;
    logic                     RST;
    logic [2*NUM_LED-1:0]     mode_reg;
    logic [CNT_W-1:0]         period_reg;
    logic [PWM_W*NUM_LED-1:0] duty_reg;
    logic [CNT_W-1:0]         clkdiv_reg;
    logic [31:0]              status_reg;
    logic [NUM_LED-1:0]       led;
    logic                     clk_out;

    int tests = 0;
    int fails = 0;
    int ones0, ones1, ones2, ones3;

    led_ctrl_multi #(
        .NUM_LED(NUM_LED),
        .CNT_W  (CNT_W),
        .PWM_W  (PWM_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .mode_reg   (mode_reg),
        .period_reg (period_reg),
        .duty_reg   (duty_reg),
        .clkdiv_reg (clkdiv_reg),
        .status_reg (status_reg),
        .led        (led),
        .clk_out    (clk_out)
    );

    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_blink(input string tag, input logic [3:0] exp_led, input logic [7:0] exp_tog);
        check({tag, "_led"}, 32'(led), 32'(exp_led));
        check({tag, "_phase"}, 32'(status_reg[17]), 32'(exp_led[0]));
        check({tag, "_stled"}, 32'(status_reg[15:0]), 32'(exp_led));
        check({tag, "_toggle"}, 32'(status_reg[31:24]), 32'(exp_tog));
    endtask

    task automatic check_div(input string tag, input logic exp_clk);
        check({tag, "_clk"}, 32'(clk_out), 32'(exp_clk));
        check({tag, "_st16"}, 32'(status_reg[16]), 32'(exp_clk));
    endtask

    task automatic count_pwm(input int n);
        ones0 = 0; ones1 = 0; ones2 = 0; ones3 = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            ones0 += int'(led[0]);
            ones1 += int'(led[1]);
            ones2 += int'(led[2]);
            ones3 += int'(led[3]);
        end
    endtask

    initial begin
        // reset, all idle
        RST = 1'b1; mode_reg = '0; period_reg = 32'd4;
        duty_reg = '0; clkdiv_reg = 32'd1000;
        step(2);
        check("rst_led", 32'(led), 32'h0);
        check("rst_clk", 32'(clk_out), 32'h0);
        check("rst_status", status_reg, 32'h0000_0000);

        // blink, period_reg = 4: toggle every 5 cycles
        mode_reg = 8'b10_10_10_10;
        RST = 1'b0;
        step(4); check_blink("blk_pre", 4'h0, 8'd0);
        step(1); check_blink("blk_t1", 4'hF, 8'd1);
        step(4); check_blink("blk_hold", 4'hF, 8'd1);
        step(1); check_blink("blk_t2", 4'h0, 8'd2);
        step(5); check_blink("blk_t3", 4'hF, 8'd3);

        // period 0: toggle every cycle, toggle counter wraps 255 -> 0
        period_reg = 32'd0;
        step(252); check_blink("wrap_255", 4'hF, 8'd255);
        step(1);   check_blink("wrap_0", 4'h0, 8'd0);
        step(1);   check_blink("wrap_1", 4'hF, 8'd1);

        // mode change latency: one cycle
        mode_reg = 8'b01_00_00_00;
        step(1);
        check("mode_lat", 32'(led), 32'h8);

        // ch0 PWM duty 64, ch1 PWM duty 0, ch2 OFF, ch3 ON
        mode_reg = 8'b01_00_11_11;
        duty_reg = 32'h0000_0040;
        step(1);
        count_pwm(256);
`ifdef LED_CTRL_PWM_EN
        check("pwm64_ch0", 32'(ones0), 32'd64);
        check("pwm0_ch1", 32'(ones1), 32'd0);
`else
        check("pwm64_ch0", 32'(ones0), 32'd256);
        check("pwm0_ch1", 32'(ones1), 32'd256);
`endif
        check("pwm_ch2_off", 32'(ones2), 32'd0);
        check("pwm_ch3_on", 32'(ones3), 32'd256);

        // duty at full scale: low for one cycle per 256
        duty_reg = 32'h0000_00FF;
        step(1);
        count_pwm(256);
`ifdef LED_CTRL_PWM_EN
        check("pwm255_ch0", 32'(ones0), 32'd255);
`else
        check("pwm255_ch0", 32'(ones0), 32'd256);
`endif

        // period shrink 100 -> 2 while blink_cnt = 50
        RST = 1'b1; mode_reg = 8'b10_10_10_10; period_reg = 32'd100; duty_reg = '0;
        step(1);
        RST = 1'b0;
        step(50); check_blink("shr_pre", 4'h0, 8'd0);
        period_reg = 32'd2;
        step(1); check_blink("shr_t1", 4'hF, 8'd1);
        step(2); check_blink("shr_hold", 4'hF, 8'd1);
        step(1); check_blink("shr_t2", 4'h0, 8'd2);
        step(3); check_blink("shr_t3", 4'hF, 8'd3);

        // reset mid-blink
        RST = 1'b1;
        step(1);
        check("mid_rst_led", 32'(led), 32'h0);
        check("mid_rst_status", status_reg, 32'h0000_0000);
        RST = 1'b0;
        step(2); check_blink("post_rst_pre", 4'h0, 8'd0);
        step(1); check_blink("post_rst_t1", 4'hF, 8'd1);

        // divider: clkdiv 0 -> CLK/2
        RST = 1'b1; mode_reg = '0; clkdiv_reg = 32'd0;
        step(1);
        RST = 1'b0;
        check_div("div0_r", 1'b0);
        step(1); check_div("div0_a", 1'b1);
        step(1); check_div("div0_b", 1'b0);
        step(1); check_div("div0_c", 1'b1);
        // clkdiv 3 from div_cnt = 0: toggle every 4 cycles
        clkdiv_reg = 32'd3;
        step(3); check_div("div3_hold", 1'b1);
        step(1); check_div("div3_t1", 1'b0);
        step(3); check_div("div3_hold2", 1'b0);
        step(1); check_div("div3_t2", 1'b1);
        // clkdiv 9 -> 2 while div_cnt = 6: toggle next cycle, then every 3
        clkdiv_reg = 32'd9;
        step(6); check_div("div_shr_pre", 1'b1);
        clkdiv_reg = 32'd2;
        step(1); check_div("div_shr_t1", 1'b0);
        step(2); check_div("div_shr_hold", 1'b0);
        step(1); check_div("div_shr_t2", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
